lc3b_seq_alu: RTL and testbench
===============================

// Module: lc3b_seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the LC-3b datapath; successor to the single-cycle ALU.
//  Executes add/and/not/pass in one cycle; shifts take SHIFT_STEP bits per cycle.
//  Adds alu_mul, a shift-add multiply returning the low WIDTH bits of the product.
//  Sits between the regfile/SR2 mux and the regfile/CC load path.
//  Uses a start/busy/done handshake so the control FSM can stall on long ops.
// PARAMETERS
//  WIDTH       16  operand/result width in bits; must be >= 2
//  SHIFT_STEP   1  bits shifted per cycle; power of 2, <= WIDTH
//  SHW        $clog2(WIDTH)  localparam: shift-amount width
// PORTS
//  clk     in   1      clock; all state updates on rising edge
//  reset   in   1      synchronous, active-high reset
//  start   in   1      request; sampled only when busy==0
//  aluop   in   4      lc3b_aluop; captured at start
//  a       in   WIDTH  operand A; captured at start
//  b       in   WIDTH  operand B (mul multiplier); captured at start
//  shamt   in   SHW    shift amount; captured at start
//  busy    out  1      high while a multi-cycle op is in flight
//  done    out  1      one-cycle pulse: result/nzp valid and updated
//  result  out  WIDTH  registered result; held until the next done
//  nzp     out  3      {n,z,p} of result, signed; exactly one bit set
// BEHAVIOUR
//  Reset (sync, wins over everything else):
//   - state=IDLE, busy=0, done=0, result=0, nzp=3'b010.
//   - An in-flight op is aborted; no done pulse follows.
//  States: IDLE, SHIFT, MUL. busy = (state != IDLE).
//  Accept: start && !busy at edge N. a, b, shamt and aluop are latched.
//   - Input changes after edge N are ignored.
//   - start while busy is ignored; it is not queued.
//  Latency L: done is high in the cycle after edge N+L-1.
//   - add/and/not/pass: L=1. State stays IDLE.
//   - sll/srl/sra: L = max(1, ceil(shamt/SHIFT_STEP)).
//     - Step k shifts by min(SHIFT_STEP, remaining bits).
//     - srl zero-fills; sra fills with the captured sign bit.
//     - shamt=0 gives result=a with L=1.
//   - mul: L=WIDTH. One multiplier bit per cycle, LSB first, starting at edge N.
//     - Accumulator is WIDTH bits; overflow is discarded. Signed and unsigned low halves agree.
//  Unknown aluop encoding: treated as alu_pass, L=1.
//  done and busy are never high together.
//  Back-to-back: start in a done cycle is accepted; no bubble.
//  result and nzp change only in the cycle done is asserted.
//  All arithmetic is modulo 2^WIDTH; no carry/overflow outputs.
// STRUCTURE
//  lc3b_types package:
//   - Widen lc3b_aluop to explicit 4-bit values: add=0, and=1, not=2, pass=3, sll=4, srl=5, sra=6.
//   - Add alu_mul=7.
//   - Add parametrisable nzp encoding constants NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001.
//  Sub-module lc3b_nzp_gen #(WIDTH): combinational result -> nzp.
//   - Its output is registered in lc3b_seq_alu on done.
//  FSM, shift counter (SHW+1 bits) and mul counter live in lc3b_seq_alu.
// TESTING (WIDTH=16, SHIFT_STEP=1 unless stated)
//  1 add a=0x7FFF b=0x0001 -> done 1 cycle later, busy never high, result=0x8000, nzp=100.
//  2 sra a=0x8010 shamt=4 -> busy high 3 cycles, done on 4th, result=0xF801, nzp=100.
//  3 mul 0x0003*0xFFFF -> done after 16 cycles, result=0xFFFD, nzp=100.
//    Then mul 0x0100*0x0100 -> result=0x0000, nzp=010.
//  4 sll a=0x0001 shamt=15; start/add pulsed mid-op -> ignored; result=0x8000.
//    start add 1+1 in the done cycle -> accepted, result=0x0002 one cycle later.
//  5 reset at cycle 5 of a mul -> busy=0 next cycle; no done; result=0x0000, nzp=010.
//  6 SHIFT_STEP=4: srl 0xF000 shamt=12 -> done after 3 cycles, result=0x000F.
//    srl 0xF000 shamt=0 -> done after 1 cycle, result=0xF000.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b ALU types: opcode encoding and the nzp condition-code constants.
// No logic and no latency. Compile this file before the ALU sources.
package lc3b_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_AND  = 4'd1,
        ALU_NOT  = 4'd2,
        ALU_PASS = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_MUL  = 4'd7
    } lc3b_aluop;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

endpackage

// File: rtl/lc3b_nzp_gen.sv
// Signed condition codes {n,z,p} for a result word; exactly one bit is set.
// Purely combinational, zero latency. Has no handshake and never stalls.
module lc3b_nzp_gen
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] result,
    output logic [2:0]       nzp
);

    always_comb begin
        nzp = NZP_P;
        if (result[WIDTH-1])
            nzp = NZP_N;
        else if (result == '0)
            nzp = NZP_Z;
    end

endmodule

// File: rtl/lc3b_seq_alu.sv
// Multi-cycle LC-3b ALU: add/and/not/pass, stepped shifts, shift-add low-half multiply.
// Latency: 1 cycle for logic/arith, ceil(shamt/SHIFT_STEP) cycles for shifts, WIDTH cycles for mul.
// Backpressure: busy is high while an op is in flight. start is ignored while busy and never queued.
module lc3b_seq_alu
    import lc3b_types::*;
#(
    parameter int WIDTH      = 16,
    parameter int SHIFT_STEP = 1,
    localparam int SHW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp
);

    localparam logic [SHW:0] STEP_W   = (SHW+1)'(SHIFT_STEP);
    localparam logic [SHW:0] MUL_LAST = (SHW+1)'(WIDTH-1);

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t           state;
    lc3b_aluop        op_in;
    lc3b_aluop        op_q;
    logic [WIDTH-1:0] sh_q;
    logic [SHW:0]     rem_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [SHW:0]     cnt_q;

    logic             accept;
    logic [WIDTH-1:0] sh_src;
    logic [SHW:0]     sh_amt;
    logic [SHW:0]     sh_step;
    logic [SHW:0]     sh_rem;
    lc3b_aluop        sh_op;
    logic [WIDTH-1:0] sh_res;
    logic [WIDTH-1:0] m_mcand;
    logic [WIDTH-1:0] m_mplier;
    logic [WIDTH-1:0] m_acc;
    logic [WIDTH-1:0] m_sum;
    logic             load_res;
    logic [WIDTH-1:0] res_nxt;
    logic [2:0]       nzp_nxt;

    // Unknown encodings fall through to the pass arm of the case below.
    assign op_in  = lc3b_aluop'(aluop);
    assign accept = start && (state == IDLE);
    assign busy   = (state != IDLE);

    // The first shift step and the first multiply bit are taken on the accept edge
    // straight from the ports, so the in-flight datapath shares the same adders/shifters.
    always_comb begin
        sh_src   = (state == SHIFT) ? sh_q  : a;
        sh_amt   = (state == SHIFT) ? rem_q : {1'b0, shamt};
        sh_op    = (state == SHIFT) ? op_q  : op_in;
        sh_step  = (sh_amt > STEP_W) ? STEP_W : sh_amt;
        sh_rem   = sh_amt - sh_step;
        case (sh_op)
            ALU_SLL: sh_res = sh_src << sh_step;
            ALU_SRL: sh_res = sh_src >> sh_step;
            default: sh_res = $unsigned($signed(sh_src) >>> sh_step);
        endcase

        m_mcand  = (state == MUL) ? mcand_q  : a;
        m_mplier = (state == MUL) ? mplier_q : b;
        m_acc    = (state == MUL) ? acc_q    : '0;
        m_sum    = m_acc + (m_mplier[0] ? m_mcand : '0);
    end

    always_comb begin
        load_res = 1'b0;
        res_nxt  = result;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op_in)
                        ALU_ADD: begin load_res = 1'b1; res_nxt = a + b; end
                        ALU_AND: begin load_res = 1'b1; res_nxt = a & b; end
                        ALU_NOT: begin load_res = 1'b1; res_nxt = ~a;    end
                        ALU_SLL, ALU_SRL, ALU_SRA: begin
                            if (sh_rem == '0) begin
                                load_res = 1'b1;
                                res_nxt  = sh_res;
                            end
                        end
                        ALU_MUL: load_res = 1'b0;
                        default: begin load_res = 1'b1; res_nxt = a; end
                    endcase
                end
            end
            SHIFT: begin
                if (sh_rem == '0) begin
                    load_res = 1'b1;
                    res_nxt  = sh_res;
                end
            end
            MUL: begin
                if (cnt_q == MUL_LAST) begin
                    load_res = 1'b1;
                    res_nxt  = m_sum;
                end
            end
            default: load_res = 1'b0;
        endcase
    end

    lc3b_nzp_gen #(.WIDTH(WIDTH)) u_nzp_gen (
        .result (res_nxt),
        .nzp    (nzp_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            result   <= '0;
            nzp      <= NZP_Z;
            op_q     <= ALU_ADD;
            sh_q     <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            done <= load_res;
            if (load_res) begin
                result <= res_nxt;
                nzp    <= nzp_nxt;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op_in;
                        if ((op_in == ALU_SLL || op_in == ALU_SRL || op_in == ALU_SRA)
                            && sh_rem != '0) begin
                            state <= SHIFT;
                            sh_q  <= sh_res;
                            rem_q <= sh_rem;
                        end
                        if (op_in == ALU_MUL) begin
                            state    <= MUL;
                            acc_q    <= m_sum;
                            mcand_q  <= a << 1;
                            mplier_q <= b >> 1;
                            cnt_q    <= (SHW+1)'(1);
                        end
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_res;
                    rem_q <= sh_rem;
                    if (sh_rem == '0)
                        state <= IDLE;
                end
                MUL: begin
                    acc_q    <= m_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == MUL_LAST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_seq_alu.sv
// Bench for lc3b_seq_alu: directed vectors, multi-cycle corner sequences, random ops vs. a reference model.
// Two instances are used, one with SHIFT_STEP=1 and one with SHIFT_STEP=4.
module tb_lc3b_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start4;
    logic [3:0]  aluop;
    logic [15:0] a, b;
    logic [3:0]  shamt;

    logic        busy1, done1, busy4, done4;
    logic [15:0] result1, result4;
    logic [2:0]  nzp1, nzp4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lc3b_seq_alu #(.WIDTH(16), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop), .a(a), .b(b),
        .shamt(shamt), .busy(busy1), .done(done1), .result(result1), .nzp(nzp1)
    );

    lc3b_seq_alu #(.WIDTH(16), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .aluop(aluop), .a(a), .b(b),
        .shamt(shamt), .busy(busy4), .done(done4), .result(result4), .nzp(nzp4)
    );

    typedef struct {
        int          d;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic [15:0] res;
        logic [2:0]  nzp;
        int          lat;
    } vec_t;

    vec_t vt[17];

    task automatic check16(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic obs_busy(int d);
        return (d != 0) ? busy4 : busy1;
    endfunction
    function automatic logic obs_done(int d);
        return (d != 0) ? done4 : done1;
    endfunction
    function automatic logic [15:0] obs_res(int d);
        return (d != 0) ? result4 : result1;
    endfunction
    function automatic logic [2:0] obs_nzp(int d);
        return (d != 0) ? nzp4 : nzp1;
    endfunction

    // Reference model: results from plain arithmetic on the op definitions.
    function automatic logic [15:0] model_res(logic [3:0] op, logic [15:0] x, logic [15:0] y, logic [3:0] sh);
        logic [31:0] p;
        case (op)
            4'd0: return x + y;
            4'd1: return x & y;
            4'd2: return ~x;
            4'd4: return x << sh;
            4'd5: return x >> sh;
            4'd6: return $unsigned($signed(x) >>> sh);
            4'd7: begin p = {16'b0, x} * {16'b0, y}; return p[15:0]; end
            default: return x;
        endcase
    endfunction

    function automatic int model_lat(logic [3:0] op, logic [3:0] sh, int step);
        int n;
        n = int'(sh);
        if (op == 4'd4 || op == 4'd5 || op == 4'd6)
            return (n == 0) ? 1 : (n + step - 1) / step;
        if (op == 4'd7)
            return 16;
        return 1;
    endfunction

    function automatic logic [2:0] model_nzp(logic [15:0] r);
        if (r[15]) return 3'b100;
        if (r == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    task automatic set_start(int d, logic v);
        if (d != 0) start4 = v; else start = v;
    endtask

    // Called at a negedge: presents an op that the next rising edge accepts.
    task automatic launch(int d, logic [3:0] op, logic [15:0] x, logic [15:0] y, logic [3:0] sh);
        aluop = op; a = x; b = y; shamt = sh;
        set_start(d, 1'b1);
    endtask

    // Follows a launched op to its done cycle; returns at the negedge where done is high.
    task automatic finish_op(int d, string name, int exp_lat, logic [15:0] exp_res,
                             logic [2:0] exp_nzp, bit mid_start);
        int k;
        int busy_cnt;
        bit held;
        logic [15:0] r0;
        busy_cnt = 0;
        held     = 1'b1;
        r0       = obs_res(d);
        @(negedge clk);
        set_start(d, 1'b0);
        k = 1;
        while (!obs_done(d) && k < 40) begin
            if (obs_busy(d)) busy_cnt++;
            if (obs_res(d) !== r0) held = 1'b0;
            a = 16'($urandom); b = 16'($urandom);
            aluop = 4'($urandom); shamt = 4'($urandom);
            if (mid_start) set_start(d, obs_busy(d) ? 1'($urandom_range(0, 1)) : 1'b0);
            @(negedge clk);
            k++;
        end
        set_start(d, 1'b0);
        if (!obs_done(d)) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=no_done required=done_within_40", name);
        end else begin
            check_int({name, ".lat"}, k, exp_lat);
            check_int({name, ".busy_cycles"}, busy_cnt, exp_lat - 1);
            check_int({name, ".busy_at_done"}, int'(obs_busy(d)), 0);
            check_int({name, ".held"}, int'(held), 1);
            check16({name, ".result"}, obs_res(d), exp_res);
            check16({name, ".nzp"}, 16'(obs_nzp(d)), 16'(exp_nzp));
        end
    endtask

    initial begin
        int nodone;
        int d;
        logic [3:0]  op;
        logic [15:0] x, y, r;
        logic [3:0]  sh;

        vt[0]  = '{0, 4'd0, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 3'b100, 1};
        vt[1]  = '{0, 4'd6, 16'h8010, 16'h0000, 4'd4,  16'hF801, 3'b100, 4};
        vt[2]  = '{0, 4'd7, 16'h0003, 16'hFFFF, 4'd0,  16'hFFFD, 3'b100, 16};
        vt[3]  = '{0, 4'd7, 16'h0100, 16'h0100, 4'd0,  16'h0000, 3'b010, 16};
        vt[4]  = '{1, 4'd5, 16'hF000, 16'h0000, 4'd12, 16'h000F, 3'b001, 3};
        vt[5]  = '{1, 4'd5, 16'hF000, 16'h0000, 4'd0,  16'hF000, 3'b100, 1};
        vt[6]  = '{0, 4'd1, 16'hF0F0, 16'h3C3C, 4'd0,  16'h3030, 3'b001, 1};
        vt[7]  = '{0, 4'd2, 16'h0000, 16'h1111, 4'd0,  16'hFFFF, 3'b100, 1};
        vt[8]  = '{0, 4'd3, 16'h1234, 16'h5555, 4'd7,  16'h1234, 3'b001, 1};
        vt[9]  = '{0, 4'd9, 16'h8000, 16'h0001, 4'd3,  16'h8000, 3'b100, 1};
        vt[10] = '{0, 4'd15, 16'h0000, 16'hFFFF, 4'd9, 16'h0000, 3'b010, 1};
        vt[11] = '{0, 4'd5, 16'h8000, 16'h0000, 4'd15, 16'h0001, 3'b001, 15};
        vt[12] = '{0, 4'd4, 16'h0001, 16'h0000, 4'd0,  16'h0001, 3'b001, 1};
        vt[13] = '{1, 4'd6, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 3'b100, 4};
        vt[14] = '{1, 4'd4, 16'h0003, 16'h0000, 4'd5,  16'h0060, 3'b001, 2};
        vt[15] = '{0, 4'd0, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 3'b010, 1};
        vt[16] = '{1, 4'd7, 16'h0007, 16'h0006, 4'd0,  16'h002A, 3'b001, 16};

        reset = 1'b1; start = 1'b0; start4 = 1'b0;
        aluop = 4'd0; a = 16'h0; b = 16'h0; shamt = 4'd0;
        repeat (3) @(negedge clk);
        check16("reset.busy",   16'(busy1),   16'h0);
        check16("reset.done",   16'(done1),   16'h0);
        check16("reset.result", result1,      16'h0000);
        check16("reset.nzp",    16'(nzp1),    16'h0002);
        check16("reset4.result", result4,     16'h0000);
        check16("reset4.nzp",   16'(nzp4),    16'h0002);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            launch(vt[i].d, vt[i].op, vt[i].a, vt[i].b, vt[i].sh);
            finish_op(vt[i].d, $sformatf("vec%0d", i), vt[i].lat, vt[i].res, vt[i].nzp, 1'b0);
            if (i % 3 == 0) @(negedge clk);
        end

        // Long shift with start pulsed mid-op, then a back-to-back add in the done cycle.
        @(negedge clk);
        launch(0, 4'd4, 16'h0001, 16'h0000, 4'd15);
        finish_op(0, "sll_midstart", 15, 16'h8000, 3'b100, 1'b1);
        launch(0, 4'd0, 16'h0001, 16'h0001, 4'd0);
        finish_op(0, "b2b_add", 1, 16'h0002, 3'b001, 1'b0);

        // Reset in the middle of a multiply aborts it with no done pulse.
        @(negedge clk);
        launch(0, 4'd7, 16'h0003, 16'h0005, 4'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check16("abort.busy",   16'(busy1), 16'h0);
        check16("abort.done",   16'(done1), 16'h0);
        check16("abort.result", result1,    16'h0000);
        check16("abort.nzp",    16'(nzp1),  16'h0002);
        reset = 1'b0;
        nodone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1 || busy1) nodone++;
        end
        check_int("abort.no_done_after", nodone, 0);

        for (int i = 0; i < 200; i++) begin
            d  = int'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15));
            x  = 16'($urandom);
            y  = 16'($urandom);
            sh = 4'($urandom);
            r  = model_res(op, x, y, sh);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(d, op, x, y, sh);
            finish_op(d, $sformatf("rnd%0d_op%0d", i, op), model_lat(op, sh, (d != 0) ? 4 : 1),
                      r, model_nzp(r), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
